// File: rtl/core_ex_mc_pkg.sv
// Shared constants for the EX stage: FSM states, RV32 opcodes, M-extension
// func7/func3 codes and branch func3 codes.
package core_ex_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/core_ex_mdu.sv
// Iterative multiply/divide unit on operand magnitudes: shift-add multiply or
// restoring divide, one bit per step_i; signs are reapplied on the result.
module core_ex_mdu
  import core_ex_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0]   hi_q, lo_q, mag_q;
  logic [2:0]        op_q;
  logic              sa_q, sb_q, done_q;
  logic              sa_en, sb_en, sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_r;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_raw, prod;

  always_comb begin
    sa_en = 1'b0;
    sb_en = 1'b0;
    case (op_i)
      F3_MULH, F3_DIV, F3_REM:             begin sa_en = 1'b1; sb_en = 1'b1; end
      F3_MULHSU:                           begin sa_en = 1'b1; sb_en = 1'b0; end
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU:  begin sa_en = 1'b0; sb_en = 1'b0; end
      default:                             begin sa_en = 1'b0; sb_en = 1'b0; end
    endcase
    sgn_a = sa_en & a_i[XLEN-1];
    sgn_b = sb_en & b_i[XLEN-1];
    mag_a = sgn_a ? -a_i : a_i;
    mag_b = sgn_b ? -b_i : b_i;

    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    div_r    = {hi_q, lo_q[XLEN-1]};
    div_diff = {1'b0, div_r} - {2'b00, mag_q};

    prod_raw = {hi_q, lo_q};
    prod     = (sa_q ^ sb_q) ? -prod_raw : prod_raw;
    if (!op_q[2])
      result_o = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])
      result_o = sa_q ? -hi_q : hi_q;
    else
      result_o = (sa_q ^ sb_q) ? -lo_q : lo_q;
  end

  assign done_o = done_q;

  // hi:lo is the product accumulator for multiply and remainder:quotient for divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      mag_q  <= '0;
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      hi_q   <= '0;
      lo_q   <= op_i[2] ? mag_a : mag_b;
      mag_q  <= op_i[2] ? mag_b : mag_a;
      op_q   <= op_i;
      sa_q   <= sgn_a;
      sb_q   <= sgn_b;
      done_q <= 1'b0;
    end else if (step_i) begin
      if (!op_q[2]) begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN+1]) begin
        hi_q <= div_diff[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_q <= div_r[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b0};
      end
      done_q <= last_i;
    end
  end

endmodule

// File: rtl/core_ex_mc.sv
// EX stage: combinational ALU/branch/jump writeback plus a multi-cycle RV32M
// path that holds the pipeline for XLEN+1 cycles (1 for div-by-zero/overflow).
module core_ex_mc
  import core_ex_mc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit MD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   inst_addr_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        func3_in,
  input  logic [6:0]        func7_in,
  input  logic              reg_we_in,
  input  logic [REG_AW-1:0] reg_write_addr_in,
  input  logic [XLEN-1:0]   reg1_data_in,
  input  logic [XLEN-1:0]   reg2_data_in,
  input  logic [XLEN-1:0]   eval_val_in,
  input  logic [XLEN-1:0]   immI_in,
  input  logic [XLEN-1:0]   immB_in,
  input  logic [XLEN-1:0]   immJ_in,
  output logic              reg_we_out,
  output logic [REG_AW-1:0] reg_write_addr_out,
  output logic [XLEN-1:0]   reg_write_data_out,
  output logic              hold_flag_out,
  output logic              jump_flag_out,
  output logic [XLEN-1:0]   jump_addr_out
);

  localparam int CW = $clog2(XLEN + 1);

  mc_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic            fast_q;
  logic [XLEN-1:0] fast_res_q;

  logic            m_enc, m_go, div0, ovf, fast, br_taken, mdu_done;
  logic [XLEN-1:0] fast_res, mdu_res, jalr_sum;

  assign m_enc = (opcode_in == OP_R) && (func7_in == F7_M);
  assign m_go  = MD_EN && m_enc;

  // Div-by-zero and signed overflow have closed-form results and skip iteration.
  assign div0     = func3_in[2] && (reg2_data_in == '0);
  assign ovf      = func3_in[2] && !func3_in[0] && (reg2_data_in == '1) &&
                    (reg1_data_in == {1'b1, {(XLEN-1){1'b0}}});
  assign fast     = div0 || ovf;
  assign fast_res = func3_in[1] ? (div0 ? reg1_data_in : '0)
                                : (div0 ? '1 : reg1_data_in);
  assign jalr_sum = reg1_data_in + immI_in;

  always_comb begin
    br_taken = 1'b0;
    case (func3_in)
      F3_BEQ:  br_taken = (reg1_data_in == reg2_data_in);
      F3_BNE:  br_taken = (reg1_data_in != reg2_data_in);
      F3_BLT:  br_taken = ($signed(reg1_data_in) <  $signed(reg2_data_in));
      F3_BGE:  br_taken = ($signed(reg1_data_in) >= $signed(reg2_data_in));
      F3_BLTU: br_taken = (reg1_data_in <  reg2_data_in);
      F3_BGEU: br_taken = (reg1_data_in >= reg2_data_in);
      default: br_taken = 1'b0;
    endcase
  end

  core_ex_mdu #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .start_i  ((state_q == ST_IDLE) && m_go && !fast),
    .step_i   (state_q == ST_BUSY),
    .last_i   (cnt_q == CW'(1)),
    .op_i     (func3_in),
    .a_i      (reg1_data_in),
    .b_i      (reg2_data_in),
    .done_o   (mdu_done),
    .result_o (mdu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m_go) begin
            if (fast) begin
              fast_q     <= 1'b1;
              fast_res_q <= fast_res;
              state_q    <= ST_DONE;
            end else begin
              fast_q  <= 1'b0;
              cnt_q   <= CW'(XLEN);
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          fast_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_we_out         = reg_we_in;
    reg_write_addr_out = reg_write_addr_in;
    reg_write_data_out = eval_val_in;
    hold_flag_out      = 1'b0;
    jump_flag_out      = 1'b0;
    jump_addr_out      = '0;
    case (opcode_in)
      OP_BRANCH: begin
        if (br_taken) begin
          jump_flag_out = 1'b1;
          jump_addr_out = inst_addr_in + immB_in;
        end
      end
      OP_JAL: begin
        jump_flag_out      = 1'b1;
        jump_addr_out      = inst_addr_in + immJ_in;
        reg_write_data_out = inst_addr_in + XLEN'(4);
      end
      OP_JALR: begin
        jump_flag_out      = 1'b1;
        jump_addr_out      = {jalr_sum[XLEN-1:1], 1'b0};
        reg_write_data_out = inst_addr_in + XLEN'(4);
      end
      default: ;
    endcase
    if (m_enc && !MD_EN) reg_write_data_out = '0;
    case (state_q)
      ST_IDLE: begin
        if (m_go) begin
          hold_flag_out = 1'b1;
          reg_we_out    = 1'b0;
        end
      end
      ST_BUSY: begin
        hold_flag_out = 1'b1;
        reg_we_out    = 1'b0;
      end
      ST_DONE: begin
        reg_we_out         = reg_we_in && (fast_q || mdu_done);
        reg_write_data_out = fast_q ? fast_res_q : mdu_res;
      end
      default: ;
    endcase
    if (reg_write_addr_in == '0) reg_we_out = 1'b0;
    if (rst) begin
      reg_we_out         = 1'b0;
      reg_write_addr_out = '0;
      reg_write_data_out = '0;
      hold_flag_out      = 1'b0;
      jump_flag_out      = 1'b0;
      jump_addr_out      = '0;
    end
  end

endmodule

// File: doc/core_ex_mc.md
CORE_EX_MC -- requirements
Module: core_ex_mc

Interface
REQ-001 Parameter XLEN, default 32: datapath width of operands, results and addresses.
REQ-002 Parameter REG_AW, default 5: register-file address width.
REQ-003 Parameter MD_EN, default 1: 1 enables the RV32M multiply/divide path; 0 makes M-encodings write zero, with no hold.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  Sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  Synchronous, active-high reset.
REQ-007 inst_addr_in  in  XLEN  PC of the instruction in EX.
REQ-008 opcode_in / func3_in / func7_in  in  7/3/7  Decoded instruction fields.
REQ-009 reg_we_in / reg_write_addr_in  in  1/REG_AW  Writeback request and rd from ID.
REQ-010 reg1_data_in / reg2_data_in  in  XLEN  rs1 and rs2 values.
REQ-011 eval_val_in  in  XLEN  Single-cycle ALU result from ID for I/R-type non-M instructions.
REQ-012 immI_in / immB_in / immJ_in  in  XLEN  Sign-extended immediates.
REQ-013 reg_we_out / reg_write_addr_out / reg_write_data_out  out  1/REG_AW/XLEN  Writeback to core_regs.
REQ-014 hold_flag_out  out  1  Asks core_ctrl to stall IF/ID and keep EX inputs stable.
REQ-015 jump_flag_out / jump_addr_out  out  1/XLEN  Redirect request to core_ctrl.

Function
REQ-016 Non-M I/R-type: reg_write_data_out = eval_val_in, with reg_we_out = reg_we_in in the same cycle (combinational, zero latency).
REQ-017 Branches: compare reg1/reg2 internally (BEQ, BNE, BLT/BGE signed, BLTU/BGEU unsigned); on taken, jump_flag_out=1 and jump_addr_out = inst_addr_in + immB_in, mod 2^XLEN.
REQ-018 JAL: jump target = inst_addr_in + immJ_in. JALR: jump target = (reg1 + immI_in) with bit0 cleared. Both write inst_addr_in + 4 to rd.
REQ-019 Default outputs when no jump: jump_flag_out=0, jump_addr_out=0, hold_flag_out=0.
REQ-020 M-instruction: opcode R with func7=0000001. Handled by an FSM with states IDLE, BUSY, DONE.
REQ-021 IDLE with M-instruction present: latch operands and func3, load counter=XLEN, go to BUSY. Assert hold_flag_out combinationally in the same cycle.
REQ-022 BUSY: one multiply/divide iteration per cycle; decrement the counter; go to DONE when the counter reaches 1.
REQ-023 The fast path bypasses BUSY and goes IDLE->DONE for:
  - divide-by-zero: quotient = all ones, remainder = dividend;
  - signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
REQ-024 DONE: hold_flag_out=0; reg_we_out = reg_we_in; drive the latched result; return to IDLE unconditionally. No restart on the same instruction.
REQ-025 Result latency: XLEN+1 cycles for a normal M-op (hold high for XLEN+1 cycles); 1 cycle for the fast path.
REQ-026 MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned 2XLEN-bit product respectively.
REQ-027 DIV/REM use truncating signed semantics: remainder takes the sign of the dividend. DIVU/REMU are unsigned.
REQ-028 reg_we_out is forced to 0 in the IDLE-start cycle and throughout BUSY; it is also 0 whenever rd = 0.

Reset
REQ-029 rst=1 at a clock edge forces IDLE, clears the counter and latched operands, and aborts any M-op in flight with no write.
REQ-030 While rst=1: every output is 0.

Structure
REQ-031 The following constants live in the shared defines.v:
  - FSM state encodings;
  - the M func7 code;
  - M func3 codes;
  - JAL/JALR opcodes.
REQ-032 The iterative shift-add multiplier / restoring divider is one sub-module, core_ex_mdu: start/done handshake, XLEN-parametrised. The FSM and muxing stay in core_ex_mc.

Verification
REQ-033 ADD, eval_val_in=0x00000007, rd=5 -> same cycle: reg_we_out=1, addr=5, data=0x7, hold_flag_out=0.
REQ-034 BLT, reg1=0xFFFFFFFF, reg2=1, PC=0x100, immB=-8 -> jump_flag_out=1, jump_addr_out=0xF8. Same operands with BLTU -> not taken.
REQ-035 MUL, reg1=0x00010000, reg2=0x00010000 -> hold high 33 cycles; DONE writes 0x0. MULHU with the same operands writes 0x1.
REQ-036 DIV, 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD. REM writes 0xFFFFFFFF.
REQ-037 DIVU x/0 -> 1-cycle hold, writes 0xFFFFFFFF. DIV 0x80000000 / -1 -> writes 0x80000000.
REQ-038 rst asserted in BUSY cycle 10 -> next cycle hold=0, reg_we_out=0; a fresh MUL afterwards completes correctly.
